// File: rtl/div_seq_pkg.sv
// Shared types and defaults for the divider job sequencer and its result FIFO.
package div_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } seq_state_e;

  localparam int unsigned DEF_WIDTH      = 32;
  localparam int unsigned DEF_FIFO_DEPTH = 4;
  localparam int unsigned DEF_TIMEOUT    = 64;

  localparam int unsigned PTR_W = $clog2(DEF_FIFO_DEPTH);
  localparam int unsigned WD_W  = $clog2(DEF_TIMEOUT + 1);

endpackage

// File: rtl/res_fifo.sv
// Registered synchronous FIFO (no fall-through) with wrap-bit pointers.
module res_fifo
  import div_seq_pkg::*;
#(
  parameter int unsigned DW    = 2 * DEF_WIDTH + 1,
  parameter int unsigned DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [DW-1:0]            wdata_i,
  input  logic                     pop_i,
  output logic [DW-1:0]            rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW:0]   wptr_q, wptr_d;
  logic [AW:0]   rptr_q, rptr_d;
  logic          do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign count_o = wptr_q - rptr_q;
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  // A full FIFO may accept a push in the same cycle it pops.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/div_job_sequencer.sv
// Issues dividend/divisor jobs to a single divider one at a time and queues results.
module div_job_sequencer
  import div_seq_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  output logic             div_start,
  output logic [WIDTH-1:0] div_x,
  output logic [WIDTH-1:0] div_y,
  input  logic             div_busy,
  input  logic             div_valid,
  input  logic             div_dbz,
  input  logic [WIDTH-1:0] div_q,
  input  logic [WIDTH-1:0] div_r,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_q,
  output logic [WIDTH-1:0] out_r,
  output logic             out_dbz,
  output logic             err_timeout,
  output logic [15:0]      jobs_done
);

  localparam int unsigned AW     = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = AW + 1;
  localparam int unsigned WDW    = $clog2(TIMEOUT + 1);
  localparam int unsigned EW     = 2 * WIDTH + 1;

  seq_state_e       state_q, state_d;
  logic [WDW-1:0]   wd_q, wd_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] x_q, x_d, y_q, y_d;
  logic [15:0]      jobs_q, jobs_d;
  logic             run_q;

  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [EW-1:0]    fifo_rdata;

  // One job in flight is tracked by the FSM itself, so busy and the FIFO full flag carry no extra information.
  logic unused_sig;
  assign unused_sig = div_busy ^ fifo_full;

  assign fifo_pop  = !fifo_empty && out_ready;
  assign out_valid = !fifo_empty;
  assign {out_q, out_r, out_dbz} = fifo_rdata;

  assign div_x       = x_q;
  assign div_y       = y_q;
  assign err_timeout = err_q;
  assign jobs_done   = jobs_q;

  always_comb begin
    state_d   = state_q;
    wd_d      = wd_q;
    err_d     = err_q;
    x_d       = x_q;
    y_d       = y_q;
    jobs_d    = jobs_q;
    fifo_push = 1'b0;
    div_start = 1'b0;
    in_ready  = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = run_q && !err_q && (fifo_count < CNT_W'(FIFO_DEPTH));
        if (in_valid && in_ready) begin
          x_d     = in_x;
          y_d     = in_y;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        div_start = 1'b1;
        wd_d      = '0;
        state_d   = WAIT;
      end
      WAIT: begin
        wd_d = wd_q + 1'b1;
        // The ISSUE cycle counts toward the budget: the flag rises TIMEOUT cycles after div_start.
        if (div_valid) begin
          fifo_push = 1'b1;
          jobs_d    = jobs_q + 16'd1;
          state_d   = IDLE;
        end else if (wd_d == WDW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      wd_q    <= '0;
      err_q   <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      jobs_q  <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
      x_q     <= x_d;
      y_q     <= y_d;
      jobs_q  <= jobs_d;
      run_q   <= 1'b1;
    end
  end

  res_fifo #(
    .DW    (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_res_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .push_i  (fifo_push),
    .wdata_i ({div_q, div_r, div_dbz}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

endmodule

// File: tb/tb_div_job_sequencer.sv
// Bench for div_job_sequencer: behavioural divider, result scoreboard, directed and random jobs.
module tb_div_job_sequencer;

  localparam int W  = 32;
  localparam int D  = 4;
  localparam int TO = 40;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_valid, in_ready;
  logic [W-1:0]  in_x, in_y;
  logic          div_start;
  logic [W-1:0]  div_x, div_y;
  logic          div_busy, div_valid, div_dbz;
  logic [W-1:0]  div_q, div_r;
  logic          out_valid, out_ready;
  logic [W-1:0]  out_q, out_r;
  logic          out_dbz, err_timeout;
  logic [15:0]   jobs_done;

  always #5 clk = ~clk;

  div_job_sequencer #(.WIDTH(W), .FIFO_DEPTH(D), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
    .div_start(div_start), .div_x(div_x), .div_y(div_y),
    .div_busy(div_busy), .div_valid(div_valid), .div_dbz(div_dbz),
    .div_q(div_q), .div_r(div_r),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_q(out_q), .out_r(out_r), .out_dbz(out_dbz),
    .err_timeout(err_timeout), .jobs_done(jobs_done)
  );

  typedef struct { logic [W-1:0] q; logic [W-1:0] r; logic dbz; } res_t;
  typedef struct { logic [W-1:0] x; logic [W-1:0] y; int lat;
                   logic [W-1:0] q; logic [W-1:0] r; logic dbz; } vec_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  res_t exp_q[$];
  int   exp_jobs = 0;

  // divider model controls
  int   lat_cfg   = 2;
  bit   hang_mode = 0;
  bit   stray_req = 0;
  int   mcnt      = 0;
  bit   aborted   = 0;
  logic [W-1:0] mx, my;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic res_t ref_div(input logic [W-1:0] x, input logic [W-1:0] y);
    res_t t;
    if (y == 0) begin t.q = '1; t.r = x; t.dbz = 1'b1; end
    else begin t.q = x / y; t.r = x % y; t.dbz = 1'b0; end
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural divider: responds lat_cfg cycles after the start pulse.
  initial begin
    bit s, h;
    int l;
    res_t t;
    div_valid = 0; div_dbz = 0; div_q = '0; div_r = '0; div_busy = 0;
    forever begin
      @(posedge clk);
      s = stray_req; h = hang_mode; l = lat_cfg;
      #1;
      div_valid = 0;
      div_dbz   = 0;
      if (!reset_n) aborted = 1;
      if (mcnt > 0) begin
        mcnt--;
        if (mcnt == 0) begin
          t = ref_div(mx, my);
          div_valid = 1; div_q = t.q; div_r = t.r; div_dbz = t.dbz;
          if (!aborted) chk("operand_hold", {div_x, div_y}, {mx, my});
        end
      end else if (s) begin
        div_valid = 1; div_q = $urandom; div_r = $urandom; div_dbz = 0;
      end
      div_busy = (mcnt > 0);
      if (div_start && !h) begin
        mcnt = l; mx = div_x; my = div_y; aborted = 0;
      end
    end
  end

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, output bit ok);
    in_x = x; in_y = y; in_valid = 1; ok = 0;
    for (int i = 0; i < 300; i++) begin
      if (in_ready) begin ok = 1; tick(); break; end
      tick();
    end
    in_valid = 0;
    chk("accept", ok, 1);
  endtask

  task automatic cmp_head(input string tag);
    if (exp_q.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL %s_unexpected: got q=%0h with no result expected", tag, out_q);
    end else begin
      chk({tag, "_q"}, out_q, exp_q[0].q);
      chk({tag, "_r"}, out_r, exp_q[0].r);
      chk({tag, "_dbz"}, out_dbz, exp_q[0].dbz);
      void'(exp_q.pop_front());
    end
  endtask

  task automatic drain(output int n);
    int guard = 0;
    n = 0;
    out_ready = 1;
    while (exp_q.size() > 0 && guard < 500) begin
      if (out_valid) begin cmp_head("drain"); n++; end
      tick();
      guard++;
    end
    out_ready = 0;
    chk("drain_complete", exp_q.size(), 0);
  endtask

  initial begin
    vec_t vecs[6];
    bit   ok;
    int   k, seen, n;
    res_t t;

    vecs[0] = '{x:100, y:7, lat:34, q:14, r:2, dbz:0};
    vecs[1] = '{x:5, y:0, lat:3, q:32'hFFFF_FFFF, r:5, dbz:1};
    vecs[2] = '{x:1000, y:10, lat:1, q:100, r:0, dbz:0};
    vecs[3] = '{x:7, y:9, lat:2, q:0, r:7, dbz:0};
    vecs[4] = '{x:32'hFFFF_FFFF, y:1, lat:5, q:32'hFFFF_FFFF, r:0, dbz:0};
    vecs[5] = '{x:9, y:3, lat:TO-1, q:3, r:0, dbz:0};

    reset_n = 0; in_valid = 0; in_x = '0; in_y = '0; out_ready = 0;
    repeat (3) tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_div_start", div_start, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_jobs", jobs_done, 0);
    chk("rst_div_x", div_x, 0);
    reset_n = 1;
    tick();
    chk("ready_after_reset", in_ready, 1);

    // Directed vectors: latency, pass-through of q/r/dbz, job count.
    foreach (vecs[i]) begin
      lat_cfg = vecs[i].lat;
      send(vecs[i].x, vecs[i].y, ok);
      chk("start_pulse", div_start, 1);
      chk("div_x", div_x, vecs[i].x);
      chk("div_y", div_y, vecs[i].y);
      chk("busy_blocks_ready", in_ready, 0);
      tick();
      chk("start_one_cycle", div_start, 0);
      k = 1;
      while (!out_valid && k < 200) begin tick(); k++; end
      chk("start_to_out_valid", k, vecs[i].lat + 1);
      chk("vec_q", out_q, vecs[i].q);
      chk("vec_r", out_r, vecs[i].r);
      chk("vec_dbz", out_dbz, vecs[i].dbz);
      exp_jobs++;
      chk("vec_jobs", jobs_done, exp_jobs);
      chk("back_to_idle", in_ready, 1);
      out_ready = 1; tick(); out_ready = 0;
      chk("popped_empty", out_valid, 0);
    end

    // Backpressure: four fill the FIFO, the fifth waits for a pop.
    lat_cfg = 2;
    for (int j = 0; j < 4; j++) begin
      send(W'(50 + 10 * j), W'(j * 3), ok);
      exp_q.push_back(ref_div(W'(50 + 10 * j), W'(j * 3)));
      exp_jobs++;
    end
    repeat (6) tick();
    in_x = 99; in_y = 4; in_valid = 1; seen = 0;
    repeat (10) begin if (in_ready) seen++; tick(); end
    chk("full_blocks_accept", seen, 0);
    out_ready = 1;
    cmp_head("bp_first");
    tick();
    out_ready = 0;
    chk("ready_after_pop", in_ready, 1);
    tick();
    in_valid = 0;
    chk("fifth_started", div_start, 1);
    exp_q.push_back(ref_div(99, 4));
    exp_jobs++;
    repeat (5) tick();
    drain(n);
    chk("bp_drained", n, 4);
    chk("bp_jobs", jobs_done, exp_jobs);

    // Stray valid while full and idle; then push and pop in the same cycle.
    for (int j = 0; j < 4; j++) begin
      send(W'(200 + j), W'(7), ok);
      exp_q.push_back(ref_div(W'(200 + j), 7));
      exp_jobs++;
    end
    repeat (6) tick();
    stray_req = 1; tick(); stray_req = 0;
    repeat (4) tick();
    chk("stray_no_count", jobs_done, exp_jobs);
    chk("stray_full_ready", in_ready, 0);
    out_ready = 1;
    cmp_head("sp_pop");
    tick();
    out_ready = 0;
    lat_cfg = 4;
    send(1234, 11, ok);
    exp_q.push_back(ref_div(1234, 11));
    exp_jobs++;
    repeat (4) tick();
    out_ready = 1;
    cmp_head("pushpop");
    tick();
    out_ready = 0;
    repeat (2) tick();
    chk("pushpop_jobs", jobs_done, exp_jobs);
    drain(n);
    chk("pushpop_occupancy", n, 3);
    chk("pushpop_empty", out_valid, 0);

    // Random traffic with a randomly stalling consumer.
    fork
      begin
        for (int j = 0; j < 40; j++) begin
          logic [W-1:0] rx, ry;
          bit rok;
          rx = $urandom;
          ry = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 5000));
          lat_cfg = $urandom_range(1, 6);
          send(rx, ry, rok);
          if (rok) begin exp_q.push_back(ref_div(rx, ry)); exp_jobs++; end
        end
      end
      begin
        int got = 0;
        for (int c = 0; c < 20000 && got < 40; c++) begin
          out_ready = ($urandom_range(0, 2) != 0);
          if (out_valid && out_ready) begin cmp_head("rand"); got++; end
          tick();
        end
        out_ready = 0;
        chk("rand_count", got, 40);
      end
    join
    chk("rand_jobs", jobs_done, exp_jobs);

    // Reset while waiting on the divider; its late result must be dropped.
    lat_cfg = 12;
    send(32'hDEAD_BEEF, 13, ok);
    repeat (3) tick();
    reset_n = 0;
    #1;
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_start", div_start, 0);
    chk("mid_rst_div_x", div_x, 0);
    chk("mid_rst_div_y", div_y, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_q", out_q, 0);
    chk("mid_rst_out_r", out_r, 0);
    chk("mid_rst_out_dbz", out_dbz, 0);
    chk("mid_rst_jobs", jobs_done, 0);
    tick(); tick();
    reset_n = 1;
    exp_q.delete();
    exp_jobs = 0;
    repeat (14) tick();
    chk("late_valid_jobs", jobs_done, 0);
    chk("late_valid_out", out_valid, 0);
    chk("late_valid_err", err_timeout, 0);

    // Watchdog: queued results still drain after the sticky error.
    lat_cfg = 3;
    for (int j = 0; j < 2; j++) begin
      send(W'(77 + j), 5, ok);
      exp_q.push_back(ref_div(W'(77 + j), 5));
      exp_jobs++;
    end
    repeat (5) tick();
    hang_mode = 1;
    send(500, 6, ok);
    chk("hang_start", div_start, 1);
    k = 0;
    while (!err_timeout && k < 200) begin tick(); k++; end
    chk("timeout_cycles", k, TO);
    chk("timeout_no_push", jobs_done, exp_jobs);
    in_valid = 1; in_x = 1; in_y = 1; seen = 0;
    repeat (10) begin if (in_ready) seen++; tick(); end
    in_valid = 0;
    chk("err_blocks_accept", seen, 0);
    drain(n);
    chk("err_drained", n, 2);
    chk("err_sticky", err_timeout, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
